// File: rtl/mp_in.sv
// Receive-side message processor: gathers 16 UART bytes into a 128-bit block
// and hands it to the core as four 32-bit words, most-significant word first.
module mp_in #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            RX_byte_in,
  input  logic                  RX_DV_in,
  input  logic                  core_ready_in,
  output logic [DATA_WIDTH-1:0] core_word_out,
  output logic                  core_dv_out,
  output logic                  busy_out,
  output logic                  overrun_out,
  output logic                  timeout_out
);

  localparam int BLOCK_BITS = 4 * DATA_WIDTH;
  localparam int NUM_BYTES  = BLOCK_BITS / 8;
  // A zero timeout still needs a one-bit counter to keep the vector legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RX_BYTES = 2'd1,
    S_SEND     = 2'd2,
    S_CLEANUP  = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [BLOCK_BITS-1:0]   buffer_reg, buffer_next;
  logic [3:0]              byte_cnt_reg, byte_cnt_next;
  logic [1:0]              word_idx_reg, word_idx_next;
  logic [TW-1:0]           tcnt_reg, tcnt_next;
  logic                    overrun_reg, overrun_next;
  logic                    timeout_reg, timeout_next;
  logic                    byte_wr;
  logic [3:0]              wr_pos;
  logic [DATA_WIDTH-1:0]   word_arr [4];

  // Byte lanes: byte k lands at the MSB end first, so byte 0 is the top byte.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign buffer_next[BLOCK_BITS-1-8*gi -: 8] =
        (byte_wr && (wr_pos == 4'(gi))) ? RX_byte_in
                                        : buffer_reg[BLOCK_BITS-1-8*gi -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign word_arr[gi] = buffer_reg[BLOCK_BITS-1-DATA_WIDTH*gi -: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      buffer_reg   <= '0;
      byte_cnt_reg <= '0;
      word_idx_reg <= '0;
      tcnt_reg     <= '0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      buffer_reg   <= buffer_next;
      byte_cnt_reg <= byte_cnt_next;
      word_idx_reg <= word_idx_next;
      tcnt_reg     <= tcnt_next;
      overrun_reg  <= overrun_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    word_idx_next = word_idx_reg;
    tcnt_next     = tcnt_reg;
    overrun_next  = 1'b0;
    timeout_next  = 1'b0;
    byte_wr       = 1'b0;
    wr_pos        = byte_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        byte_cnt_next = '0;
        if (RX_DV_in) begin
          byte_wr       = 1'b1;
          wr_pos        = '0;
          byte_cnt_next = 4'd1;
          tcnt_next     = '0;
          state_next    = S_RX_BYTES;
        end
      end
      S_RX_BYTES: begin
        if (RX_DV_in) begin
          // A byte on the timeout cycle wins over the timeout.
          byte_wr       = 1'b1;
          byte_cnt_next = byte_cnt_reg + 4'd1;
          tcnt_next     = '0;
          if (byte_cnt_reg == 4'(NUM_BYTES - 1)) begin
            word_idx_next = '0;
            state_next    = S_SEND;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tcnt_reg == T_LAST)) begin
          timeout_next  = 1'b1;
          byte_cnt_next = '0;
          state_next    = S_IDLE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      S_SEND: begin
        overrun_next = RX_DV_in;
        if (core_ready_in) begin
          word_idx_next = word_idx_reg + 2'd1;
          if (word_idx_reg == 2'd3) state_next = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        overrun_next = RX_DV_in;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_word_out = '0;
    core_dv_out   = 1'b0;
    busy_out      = (state_reg != S_IDLE);
    if (state_reg == S_SEND) begin
      core_dv_out   = 1'b1;
      core_word_out = word_arr[word_idx_reg];
    end
  end

  assign overrun_out = overrun_reg;
  assign timeout_out = timeout_reg;

endmodule

// File: tb/tb_mp_in.sv
// Directed and randomized checks of mp_in against a byte-queue reference model.
module tb_mp_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  RX_byte_in = '0;
  logic        RX_DV_in = 1'b0;
  logic        core_ready_in = 1'b1;
  logic [31:0] core_word_out;
  logic        core_dv_out, busy_out, overrun_out, timeout_out;

  int vectors = 0;
  int miscompares = 0;
  int dv_cycles = 0;
  int overrun_cnt = 0;
  int timeout_cnt = 0;
  bit rnd_ready = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  blk [16];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_word = '0;

  mp_in #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .RX_byte_in(RX_byte_in), .RX_DV_in(RX_DV_in),
    .core_ready_in(core_ready_in), .core_word_out(core_word_out),
    .core_dv_out(core_dv_out), .busy_out(busy_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold && core_dv_out) chk("hold_stable", core_word_out, prev_word);
      if (!core_dv_out) chk("idle_word_zero", core_word_out, 32'h0);
      if (core_dv_out) dv_cycles++;
      if (core_dv_out && core_ready_in) got_q.push_back(core_word_out);
      if (overrun_out) overrun_cnt++;
      if (timeout_out) timeout_cnt++;
      prev_hold = core_dv_out && !core_ready_in;
      prev_word = core_word_out;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_byte_in = b;
    RX_DV_in   = 1'b1;
    tick();
    RX_DV_in   = 1'b0;
  endtask

  // Reference model: block words are four consecutive bytes, first byte on top.
  task automatic model_block();
    for (int j = 0; j < 4; j++)
      exp_q.push_back({blk[4*j], blk[4*j+1], blk[4*j+2], blk[4*j+3]});
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int k = 0; k < 16; k++) blk[k] = base + 8'(k);
  endtask

  task automatic send_blk(input int gap_max);
    for (int k = 0; k < 16; k++) begin
      send_byte(blk[k]);
      if (k != 15 && gap_max > 0) begin
        int g = int'($urandom_range(gap_max, 0));
        for (int i = 0; i < g; i++) tick();
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_out && n < 300) begin
      core_ready_in = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      tick();
      n++;
    end
    core_ready_in = 1'b1;
    chk({tag, "_idle_bound"}, {31'h0, busy_out}, 32'h0);
  endtask

  task automatic check_got(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [6:0] pat;
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_word", core_word_out, 32'h0);
    chk("rst_dv", {31'h0, core_dv_out}, 32'h0);
    chk("rst_busy", {31'h0, busy_out}, 32'h0);
    chk("rst_ovr", {31'h0, overrun_out}, 32'h0);
    chk("rst_tmo", {31'h0, timeout_out}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Block 0x00..0x0F with ready high; exact cycle timing.
    fill_seq(8'h00); model_block(); dv_cycles = 0;
    send_blk(0);
    chk("t1_w0", core_word_out, 32'h00010203);
    chk("t1_dv", {31'h0, core_dv_out}, 32'h1);
    tick(); chk("t1_w1", core_word_out, 32'h04050607);
    tick(); chk("t1_w2", core_word_out, 32'h08090A0B);
    tick(); chk("t1_w3", core_word_out, 32'h0C0D0E0F);
    tick(); chk("t1_cleanup_dv", {31'h0, core_dv_out}, 32'h0);
    chk("t1_cleanup_busy", {31'h0, busy_out}, 32'h1);
    tick(); chk("t1_idle_busy", {31'h0, busy_out}, 32'h0);
    chk("t1_dv_cycles", dv_cycles, 4);
    check_got("t1");

    // Ready toggled 1,0,0,1,0,1,1 (MSB applied first).
    fill_seq(8'h00); model_block();
    pat = 7'b1001011;
    send_blk(0);
    for (int i = 6; i >= 0; i--) begin
      core_ready_in = pat[i];
      tick();
    end
    core_ready_in = 1'b1;
    wait_idle("t2");
    check_got("t2");

    // Timeout after 5 bytes, exact pulse cycle.
    timeout_cnt = 0;
    for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k));
    for (int i = 0; i < 19; i++) tick();
    chk("t3_pre_tmo", {31'h0, timeout_out}, 32'h0);
    chk("t3_pre_busy", {31'h0, busy_out}, 32'h1);
    tick();
    chk("t3_tmo_pulse", {31'h0, timeout_out}, 32'h1);
    chk("t3_tmo_idle", {31'h0, busy_out}, 32'h0);
    for (int i = 0; i < 30; i++) tick();
    chk("t3_tmo_once", timeout_cnt, 1);
    fill_seq(8'hA0); model_block();
    send_blk(0);
    chk("t3_first_word", core_word_out, 32'hA0A1A2A3);
    wait_idle("t3");
    check_got("t3");

    // Byte landing on the would-be timeout edge wins.
    timeout_cnt = 0;
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    model_block();
    send_byte(blk[0]);
    for (int i = 0; i < 19; i++) tick();
    for (int k = 1; k < 16; k++) send_byte(blk[k]);
    wait_idle("t4");
    chk("t4_no_tmo", timeout_cnt, 0);
    check_got("t4");

    // 17th byte during a stalled send is dropped with one overrun pulse.
    overrun_cnt = 0;
    fill_seq(8'h30); model_block();
    core_ready_in = 1'b0;
    send_blk(0);
    tick();
    send_byte(8'hEE);
    chk("t5_ovr_pulse", {31'h0, overrun_out}, 32'h1);
    chk("t5_word_held", core_word_out, 32'h30313233);
    tick();
    chk("t5_ovr_end", {31'h0, overrun_out}, 32'h0);
    wait_idle("t5");
    chk("t5_ovr_once", overrun_cnt, 1);
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
    model_block();
    send_blk(2);
    wait_idle("t5b");
    check_got("t5");

    // Byte in the cleanup cycle is an overrun; next cycle starts a new block.
    overrun_cnt = 0;
    fill_seq(8'h60); model_block();
    send_blk(0);
    for (int i = 0; i < 4; i++) tick();
    send_byte(8'hDD);
    fill_seq(8'h70); model_block();
    send_blk(0);
    wait_idle("t6");
    chk("t6_ovr_cleanup", overrun_cnt, 1);
    check_got("t6");

    // Reset after 9 bytes aborts the block.
    for (int k = 0; k < 9; k++) send_byte(8'hC0 + 8'(k));
    rst_n = 1'b0;
    tick(); tick();
    chk("t7_rst_busy", {31'h0, busy_out}, 32'h0);
    rst_n = 1'b1;
    tick();
    fill_seq(8'h10); model_block();
    send_blk(0);
    wait_idle("t7");
    check_got("t7");

    // Second block starting exactly at N+6: no overrun, both intact.
    overrun_cnt = 0;
    fill_seq(8'h80); model_block();
    send_blk(0);
    for (int i = 0; i < 5; i++) tick();
    fill_seq(8'h90); model_block();
    send_blk(0);
    wait_idle("t8");
    chk("t8_no_ovr", overrun_cnt, 0);
    check_got("t8");

    // Randomized blocks with random gaps and random ready.
    rnd_ready = 1'b1;
    timeout_cnt = 0;
    for (int b = 0; b < 20; b++) begin
      for (int k = 0; k < 16; k++) blk[k] = 8'($urandom);
      model_block();
      send_blk(6);
      wait_idle($sformatf("rnd%0d", b));
    end
    check_got("rnd");
    chk("rnd_no_tmo", timeout_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mp_in.md
# mp_in

Receive-side message processor: collects 16 bytes from the UART receiver and assembles them into a 128-bit block. It then hands the block to the AES core as four 32-bit words, most-significant word first, over a valid/ready handshake. It sits between the UART RX byte interface and the core's word input, and is the inbound mirror of the outbound word-to-byte serializer. A partial block is discarded if the byte stream stalls beyond a programmable timeout.

## Interface
- DATA_WIDTH, 32, core word width; only 32 is supported (4 words × 32 = 128 bits).
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of one block before the partial block is discarded; 0 disables the timeout.
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- RX_byte_in  in  8  received byte; valid only when RX_DV_in=1.
- RX_DV_in  in  1  one-cycle strobe from the UART receiver, one per byte.
- core_ready_in  in  1  core accepts core_word_out this cycle.
- core_word_out  out  DATA_WIDTH  current block word; 0 outside s_SEND.
- core_dv_out  out  1  word valid; high throughout s_SEND.
- busy_out  out  1  high in s_RX_BYTES, s_SEND and s_CLEANUP.
- overrun_out  out  1  one-cycle pulse when a byte is dropped.
- timeout_out  out  1  one-cycle pulse when a partial block is discarded.

## Operation
- Registers:
  - 128-bit block buffer.
  - 4-bit byte counter.
  - 2-bit word index.
  - Timeout counter, width $clog2(TIMEOUT_CYCLES+1).
- Byte k (0..15) is stored at buffer[127-8k -: 8], so the first byte received is the MSB.
- Word j (0..3) is buffer[127-32j -: 32].
- State machine, four states:
  - s_IDLE:
    - byte counter = 0.
    - On RX_DV_in: store byte 0, counter←1, timeout counter←0, go to s_RX_BYTES.
  - s_RX_BYTES:
    - On RX_DV_in: store byte at the counter position, counter+1, timeout counter←0.
    - If that byte is byte 15: go to s_SEND with word index←0.
    - With no RX_DV_in: timeout counter+1.
    - If TIMEOUT_CYCLES≠0 and the timeout counter equals TIMEOUT_CYCLES-1 with no RX_DV_in this cycle: pulse timeout_out, counter←0, go to s_IDLE. The buffer contents are left unchanged.
    - A byte arriving on the same cycle as the timeout wins: it is stored and there is no timeout.
  - s_SEND:
    - core_dv_out=1 and core_word_out = word[index].
    - A transfer occurs on a cycle with core_dv_out & core_ready_in; the index then increments.
    - The transfer with index=3 moves the state to s_CLEANUP.
    - While core_ready_in is low, the word holds stable.
    - Any RX_DV_in is dropped and pulses overrun_out.
  - s_CLEANUP:
    - Lasts one cycle, with outputs at idle values.
    - Any RX_DV_in is dropped and pulses overrun_out.
    - Next state is s_IDLE.
- Unused encodings go to s_IDLE.
- The block is never modified while s_SEND is active.

## Timing
- Reset values:
  - State s_IDLE; all counters and the buffer 0.
  - core_word_out=0, core_dv_out=0, busy_out=0, overrun_out=0, timeout_out=0.
- Reset asserted mid-block or mid-send aborts immediately. No partial words are emitted after release.
- 16th RX_DV_in at edge N → core_dv_out=1 with word 0 from cycle N+1.
- With core_ready_in held high, words 0..3 are presented in cycles N+1..N+4, s_CLEANUP is at N+5 and s_IDLE at N+6.
- The first byte of the next block is accepted from cycle N+6. An RX_DV_in in cycles N+1..N+5 is an overrun.
- Back-to-back RX_DV_in on consecutive cycles are all captured; there is no minimum byte spacing.
- overrun_out and timeout_out are registered. Each is high for exactly one cycle, the cycle after the causing edge.
- busy_out is combinational from the state.

## Test plan
- Reset, then bytes 0x00..0x0F with core_ready_in=1 → words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on consecutive cycles; core_dv_out high for exactly 4 cycles.
- Same stream, core_ready_in toggled 1,0,0,1,0,1,1 → each word held stable while ready=0; exactly 4 transfers in order; no word repeated or skipped.
- TIMEOUT_CYCLES=20:
  - 5 bytes, then silence → timeout_out pulses once, state returns to s_IDLE.
  - Then 16 bytes 0xA0..0xAF → first word 0xA0A1A2A3.
- A 17th byte sent while in s_SEND with core_ready_in=0 → overrun_out pulses once; emitted words are unchanged; the dropped byte does not appear as the start of the next block.
- rst_n pulsed low after 9 bytes, then 16 fresh bytes 0x10..0x1F → only the words 0x10111213..0x1C1D1E1F appear.
- Two blocks with the second block's first byte at exactly N+6 → both blocks delivered intact; no overrun.
